// File: rtl/glitch_sweep_ctrl.sv
// Sweep controller for a glitch engine: walks a (delay, width) grid, arms the engine once per
// point, watches the fault monitor through each attempt and records faulting points.
module glitch_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] delay_start,
    input  logic [31:0] delay_step,
    input  logic [31:0] delay_end,
    input  logic [31:0] width_start,
    input  logic [31:0] width_step,
    input  logic [31:0] width_end,
    input  logic        engine_done,
    input  logic        fault_in,
    output logic        arm,
    output logic [31:0] cur_delay,
    output logic [31:0] cur_width,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        hit_valid,
    output logic [31:0] hit_delay,
    output logic [31:0] hit_width,
    output logic [15:0] hit_count,
    output logic [31:0] attempts,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RELEASE,
        ST_SETTLE,
        ST_STEP,
        ST_FINISH
    } state_t;

    localparam logic [31:0] LP_SETTLE_LAST = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;
    localparam logic [31:0] LP_TMO_LAST    = TIMEOUT_CYCLES - 32'd1;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_dstep, r_dend, r_wstart, r_wstep, r_wend;
    logic [31:0] r_cur_delay, r_cur_width;
    logic [31:0] r_hit_delay, r_hit_width;
    logic [15:0] r_hit_count;
    logic [31:0] r_attempts;
    logic [31:0] r_cnt;
    logic        r_fault;
    logic        r_busy, r_aborted, r_hit_valid, r_timeout_err;

    logic [32:0] w_next_w, w_next_d;
    logic        w_w_wrap, w_d_wrap;
    logic        w_range_bad, w_abort, w_tmo, w_settle_end;

    // 33-bit sums so a carry out of the 32-bit range counts as past-end, never as a wrap
    assign w_next_w     = {1'b0, r_cur_width} + {1'b0, r_wstep};
    assign w_next_d     = {1'b0, r_cur_delay} + {1'b0, r_dstep};
    assign w_w_wrap     = (r_wstep == 32'd0) || w_next_w[32] || (w_next_w[31:0] > r_wend);
    assign w_d_wrap     = (r_dstep == 32'd0) || w_next_d[32] || (w_next_d[31:0] > r_dend);
    assign w_range_bad  = (delay_start > delay_end) || (width_start > width_end);
    assign w_abort      = abort && (r_state != ST_IDLE);
    assign w_tmo        = (r_cnt == LP_TMO_LAST);
    assign w_settle_end = (r_cnt == LP_SETTLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = w_range_bad ? ST_FINISH : ST_ARM;
            ST_ARM: begin
                if (engine_done)  w_state_nxt = ST_RELEASE;
                else if (w_tmo)   w_state_nxt = ST_FINISH;
            end
            ST_RELEASE: begin
                if (!engine_done) w_state_nxt = ST_SETTLE;
                else if (w_tmo)   w_state_nxt = ST_FINISH;
            end
            ST_SETTLE:  if (w_settle_end) w_state_nxt = ST_STEP;
            ST_STEP:    w_state_nxt = (w_w_wrap && w_d_wrap) ? ST_FINISH : ST_ARM;
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dstep       <= '0;
            r_dend        <= '0;
            r_wstart      <= '0;
            r_wstep       <= '0;
            r_wend        <= '0;
            r_cur_delay   <= '0;
            r_cur_width   <= '0;
            r_hit_delay   <= '0;
            r_hit_width   <= '0;
            r_hit_count   <= '0;
            r_attempts    <= '0;
            r_cnt         <= '0;
            r_fault       <= 1'b0;
            r_busy        <= 1'b0;
            r_aborted     <= 1'b0;
            r_hit_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_aborted   <= 1'b0;
            r_hit_valid <= 1'b0;
            if (w_abort) begin
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: if (start) begin
                        r_dstep       <= delay_step;
                        r_dend        <= delay_end;
                        r_wstart      <= width_start;
                        r_wstep       <= width_step;
                        r_wend        <= width_end;
                        r_cur_delay   <= delay_start;
                        r_cur_width   <= width_start;
                        r_attempts    <= '0;
                        r_hit_count   <= '0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                        r_fault       <= 1'b0;
                    end
                    ST_ARM: begin
                        r_fault <= r_fault | fault_in;
                        if (engine_done)  r_cnt <= '0;
                        else if (w_tmo)   r_timeout_err <= 1'b1;
                        else              r_cnt <= r_cnt + 32'd1;
                    end
                    ST_RELEASE: begin
                        r_fault <= r_fault | fault_in;
                        if (!engine_done) r_cnt <= '0;
                        else if (w_tmo)   r_timeout_err <= 1'b1;
                        else              r_cnt <= r_cnt + 32'd1;
                    end
                    ST_SETTLE: begin
                        r_fault <= r_fault | fault_in;
                        r_cnt   <= w_settle_end ? 32'd0 : r_cnt + 32'd1;
                    end
                    ST_STEP: begin
                        r_attempts <= r_attempts + 32'd1;
                        r_cnt      <= '0;
                        r_fault    <= 1'b0;
                        if (r_fault) begin
                            r_hit_delay <= r_cur_delay;
                            r_hit_width <= r_cur_width;
                            r_hit_valid <= 1'b1;
                            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
                        end
                        // width is the inner loop; cur_* keep the last point when the sweep ends
                        if (!w_w_wrap) begin
                            r_cur_width <= w_next_w[31:0];
                        end else if (!w_d_wrap) begin
                            r_cur_width <= r_wstart;
                            r_cur_delay <= w_next_d[31:0];
                        end
                    end
                    ST_FINISH: r_busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // arm decodes straight from the state register so reset and abort drop it without a clock
    assign arm         = (r_state == ST_ARM) && !abort;
    assign done        = (r_state == ST_FINISH) && !abort;
    assign busy        = r_busy;
    assign aborted     = r_aborted;
    assign hit_valid   = r_hit_valid;
    assign cur_delay   = r_cur_delay;
    assign cur_width   = r_cur_width;
    assign hit_delay   = r_hit_delay;
    assign hit_width   = r_hit_width;
    assign hit_count   = r_hit_count;
    assign attempts    = r_attempts;
    assign timeout_err = r_timeout_err;

endmodule
